// File: rtl/alu_div_iter_pkg.sv
// Shared types for the execute-stage ALU and its iterative divider.
// Divider FSM states live here so the execute stage can observe them.
package alu_div_iter_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI,
        ALU_DIV,
        ALU_DIVU
    } alu_function;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_PREP,
        DIV_ITER,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
// Combinational; the caller registers the partial remainder.
module alu_div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   rem_i,
    input  logic         msb_i,
    input  logic [N-1:0] dvs_i,
    output logic [N:0]   rem_o,
    output logic         q_o
);

    logic [N+1:0] shifted;
    logic [N+1:0] diff;

    always_comb begin
        shifted = {rem_i, msb_i};
        diff    = shifted - {2'b00, dvs_i};
        q_o     = ~diff[N+1];
        rem_o   = q_o ? diff[N:0] : shifted[N:0];
    end

endmodule

// File: rtl/alu_div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Signed operands are divided as magnitudes and the signs fixed up at the end.
module alu_div_iter
    import alu_div_iter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_t    state_q, state_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N:0]    rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sgn_q, sgn_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          zero_q, zero_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  remo_q, remo_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    step_rem;
    logic          step_q;

    alu_div_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .msb_i (dvd_q[N-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start && !abort) begin
                    state_d = DIV_PREP;
                    dvd_d   = a;
                    dvs_d   = b;
                    sgn_d   = is_signed;
                end
            end
            DIV_PREP: begin
                if (abort) begin
                    state_d = DIV_IDLE;
                end else if (dvs_q == '0) begin
                    // Skip the iterations but keep the FIX slot for latency.
                    state_d = DIV_FIX;
                    zero_d  = 1'b1;
                end else begin
                    state_d = DIV_ITER;
                    zero_d  = 1'b0;
                    qneg_d  = sgn_q & (dvd_q[N-1] ^ dvs_q[N-1]);
                    rneg_d  = sgn_q & dvd_q[N-1];
                    if (sgn_q && dvd_q[N-1]) dvd_d = -dvd_q;
                    if (sgn_q && dvs_q[N-1]) dvs_d = -dvs_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                end
            end
            DIV_ITER: begin
                if (abort) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[N-2:0], step_q};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                if (abort) begin
                    state_d = DIV_IDLE;
                end else if (zero_q) begin
                    state_d = DIV_DONE;
                    quot_d  = '1;
                    remo_d  = dvd_q;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = DIV_DONE;
                    quot_d  = qneg_q ? -dvd_q : dvd_q;
                    remo_d  = rneg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
                    dbz_d   = 1'b0;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == DIV_PREP) || (state_q == DIV_ITER)
                         || (state_q == DIV_FIX);
    assign done        = (state_q == DIV_DONE);
    assign div_by_zero = dbz_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;

endmodule

// File: tb/tb_alu_div_iter.sv
// Scoreboard bench for the iterative divider: latency, results, abort, reset.
// Expected results are queued at start and popped on each done pulse.
module tb_alu_div_iter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         is_signed;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] last_q = '0;
    logic [N-1:0] last_r = '0;
    logic         last_dbz = 1'b0;

    always #5 clk = ~clk;

    alu_div_iter #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, required no done");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (quotient !== e.q) begin
                    errors++;
                    $display("FAIL quotient: got %h, required %h",
                             quotient, e.q);
                end
                checks++;
                if (remainder !== e.r) begin
                    errors++;
                    $display("FAIL remainder: got %h, required %h",
                             remainder, e.r);
                end
                checks++;
                if (div_by_zero !== e.dbz) begin
                    errors++;
                    $display("FAIL div_by_zero: got %b, required %b",
                             div_by_zero, e.dbz);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb2,
                          input logic ts, input logic [N-1:0] eq,
                          input logic [N-1:0] er, input logic ed,
                          input int elat, input int inj, input bit hold);
        int   lat;
        bit   seen;
        exp_t e;
        e.q = eq;
        e.r = er;
        e.dbz = ed;
        exp_q.push_back(e);
        last_q = eq;
        last_r = er;
        last_dbz = ed;
        if (!hold) @(negedge clk);
        a = ta;
        b = tb2;
        is_signed = ts;
        start = 1'b1;
        // With hold, start is already high during DONE and must be ignored.
        if (hold) @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        is_signed = ~ts;
        lat = 0;
        seen = 1'b0;
        @(negedge clk);
        while (!seen && lat <= elat + 5) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_during_op: got %b at cycle %0d, required 1",
                             busy, lat);
                end
                if (lat == inj) begin
                    start = 1'b1;
                    a = 32'd9;
                    b = 32'd3;
                    is_signed = 1'b0;
                end
                @(posedge clk);
                #1;
                start = 1'b0;
                lat++;
                @(negedge clk);
            end
        end
        checks++;
        if (!seen || lat != elat) begin
            errors++;
            $display("FAIL latency: got %0d (seen=%0b), required %0d",
                     lat, seen, elat);
        end
        if (seen) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_done: got %b, required 0", busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 000",
                     {busy, done, div_by_zero});
        end
        checks++;
        if (quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset_results: got %h/%h, required 0/0",
                     quotient, remainder);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, -1, 1'b0);
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0,
               34, -1, 1'b0);
        run_op(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0,
               34, -1, 1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0,
               34, -1, 1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0,
               34, -1, 1'b0);
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0,
               34, -1, 1'b0);
    endtask

    task automatic test_div_zero();
        run_op(32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b1,
               2, -1, 1'b0);
        run_op(32'h1234, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h1234, 1'b1,
               2, -1, 1'b0);
        run_op(32'hFFFFFF00, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFF00, 1'b1,
               2, -1, 1'b0);
        run_op(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0, 34, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [N-1:0] ra, rb;
        int sa, sb;
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? N'($urandom_range(1, 1000)) : N'($urandom);
            if (rb == '0) rb = 32'd1;
            if (i < 5) begin
                run_op(ra, rb, 1'b0, ra / rb, ra % rb, 1'b0, 34, -1, 1'b0);
            end else begin
                sa = int'(ra);
                sb = int'(rb);
                if (sa == int'(32'h80000000) && sb == -1) sb = 3;
                run_op(ra, N'(sb), 1'b1, N'(sa / sb), N'(sa % sb), 1'b0,
                       34, -1, 1'b0);
            end
        end
    endtask

    task automatic test_abort();
        int nd;
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b, required 0", busy);
        end
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, required 0", nd);
        end
        checks++;
        if (quotient !== last_q || remainder !== last_r
            || div_by_zero !== last_dbz) begin
            errors++;
            $display("FAIL abort_hold: got %h/%h/%b, required %h/%h/%b",
                     quotient, remainder, div_by_zero,
                     last_q, last_r, last_dbz);
        end
        run_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 34, -1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 5, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 34, -1, 1'b0);
        run_op(32'd77, 32'd8, 1'b0, 32'd9, 32'd5, 1'b0, 34, -1, 1'b1);
        run_op(32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd5, 1'b1, 2, -1, 1'b1);
    endtask

    task automatic test_start_abort_idle();
        int nb;
        @(negedge clk);
        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        nb = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1) nb++;
        end
        checks++;
        if (nb != 0) begin
            errors++;
            $display("FAIL start_abort_idle: got %0d active cycles, required 0",
                     nb);
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000
            || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %b %h/%h, required 000 0/0",
                     {busy, done, div_by_zero}, quotient, remainder);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles, required 0",
                     nd);
        end
        run_op(32'd64, 32'd4, 1'b1, 32'd16, 32'd0, 1'b0, 34, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_random();
        test_abort();
        test_start_while_busy();
        test_back_to_back();
        test_start_abort_idle();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
